// File: rtl/dp_pkg.sv
// Shared definitions for the multi-cycle datapath: CTRL bit layout, ALU and
// write-back encodings, memory FSM states and the stack-pointer reset value.
package dp_pkg;

  localparam int CTRL_W         = 14;
  localparam int CTRL_PC_LOAD   = 13;
  localparam int CTRL_PC_SEL    = 12;
  localparam int CTRL_IR_LOAD   = 11;
  localparam int CTRL_REG_WRITE = 10;
  localparam int CTRL_WB_SEL    = 8;   // 2-bit field, LSB position
  localparam int CTRL_ALU_SRC   = 7;
  localparam int CTRL_ALU_OP    = 3;   // 4-bit field, LSB position
  localparam int CTRL_MEM_RD    = 2;
  localparam int CTRL_MEM_WR    = 1;
  localparam int CTRL_RSVD      = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_NOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_LUI = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU_RD  = 2'd0,
    WB_ALU_RT  = 2'd1,
    WB_MDR_RT  = 2'd2,
    WB_PC_LINK = 2'd3
  } wb_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam logic [31:0] STACK_TOP = 32'h03FF_FFFF;

endpackage

// File: rtl/reg_file_mc.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 is hard-wired to zero; the second-highest register holds the stack top at reset.
module reg_file_mc #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_COUNT  = 32,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(REG_COUNT)-1:0] ra_addr,
  input  logic [$clog2(REG_COUNT)-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0]        ra_data,
  output logic [DATA_WIDTH-1:0]        rb_data,
  input  logic                         we,
  input  logic [$clog2(REG_COUNT)-1:0] wa,
  input  logic [DATA_WIDTH-1:0]        wd
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == REG_COUNT - 2) ? SP_RESET : '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/data_path_mc.sv
// Multi-cycle CPU datapath: PC, IR, MDR, ALU_OUT, register file, ALU and a
// two-state memory handshake FSM that stalls the datapath while BUSY.
module data_path_mc
  import dp_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    REG_COUNT  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'('h0001000)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CTRL_W-1:0]     CTRL,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  MEM_ACK,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic                  BUSY,
  output logic                  ZERO,
  output logic [DATA_WIDTH-1:0] INSTRUCTION
);

  localparam int RIDX = $clog2(REG_COUNT);

  logic                   pc_load, pc_sel, ir_load, reg_write, alu_src, mem_rd, mem_wr;
  wb_sel_e                wb_sel;
  alu_op_e                alu_op;
  mem_state_e             state;
  logic                   mem_we_q;
  logic                   idle, rf_we, unused_bits;
  logic [DATA_WIDTH-1:0]  pc, ir, mdr, alu_out;
  logic [DATA_WIDTH-1:0]  imm, alu_a, alu_b, alu_res, rs_data, rt_data, rf_wdata;
  logic signed [DATA_WIDTH-1:0] alu_a_s, alu_b_s;
  logic [31:0]            ir_ext;
  logic [RIDX-1:0]        rs, rt, rd, rf_waddr;

  assign pc_load   = CTRL[CTRL_PC_LOAD];
  assign pc_sel    = CTRL[CTRL_PC_SEL];
  assign ir_load   = CTRL[CTRL_IR_LOAD];
  assign reg_write = CTRL[CTRL_REG_WRITE];
  assign wb_sel    = wb_sel_e'(CTRL[CTRL_WB_SEL +: 2]);
  assign alu_src   = CTRL[CTRL_ALU_SRC];
  assign alu_op    = alu_op_e'(CTRL[CTRL_ALU_OP +: 4]);
  assign mem_rd    = CTRL[CTRL_MEM_RD];
  assign mem_wr    = CTRL[CTRL_MEM_WR];

  // Field positions assume a 32-bit instruction word; narrower builds zero-extend IR.
  assign ir_ext = 32'(ir);
  assign rs     = ir_ext[25 -: RIDX];
  assign rt     = ir_ext[20 -: RIDX];
  assign rd     = ir_ext[15 -: RIDX];
  assign imm    = DATA_WIDTH'($signed(ir[15:0]));

  assign unused_bits = ^{CTRL[CTRL_RSVD], ir_ext};

  assign idle  = (state == ST_IDLE);
  assign rf_we = reg_write && idle;

  always_comb begin
    rf_waddr = rd;
    rf_wdata = alu_out;
    case (wb_sel)
      WB_ALU_RT:  rf_waddr = rt;
      WB_MDR_RT:  begin rf_waddr = rt; rf_wdata = mdr; end
      WB_PC_LINK: begin rf_waddr = RIDX'(REG_COUNT - 1); rf_wdata = pc; end
      default:    ;
    endcase
  end

  reg_file_mc #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .SP_RESET   (DATA_WIDTH'(STACK_TOP))
  ) u_rf (
    .clk     (CLK),
    .rst_n   (RST),
    .ra_addr (rs),
    .rb_addr (rt),
    .ra_data (rs_data),
    .rb_data (rt_data),
    .we      (rf_we),
    .wa      (rf_waddr),
    .wd      (rf_wdata)
  );

  assign alu_a   = rs_data;
  assign alu_b   = alu_src ? imm : rt_data;
  assign alu_a_s = alu_a;
  assign alu_b_s = alu_b;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_NOR: alu_res = ~(alu_a | alu_b);
      ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, (alu_a_s < alu_b_s)};
      ALU_SLL: alu_res = alu_a << alu_b[4:0];
      ALU_SRL: alu_res = alu_a >> alu_b[4:0];
      ALU_LUI: alu_res = imm << 16;
      default: alu_res = '0;
    endcase
  end

  // Memory handshake FSM; CTRL is held stable by the control unit while in WAIT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      mem_we_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (ir_load || mem_rd || mem_wr) begin
          state    <= ST_WAIT;
          mem_we_q <= mem_wr;
        end
        ST_WAIT: if (MEM_ACK) begin
          state    <= ST_IDLE;
          mem_we_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Architectural registers freeze while BUSY, which keeps ADDR and DATA_OUT stable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      alu_out <= '0;
    end else if (idle) begin
      alu_out <= alu_res;
      if (pc_load) pc <= pc_sel ? alu_out : pc + DATA_WIDTH'(1);
    end else if (MEM_ACK) begin
      if (ir_load)           ir  <= DATA_IN;
      if (mem_rd && !mem_wr) mdr <= DATA_IN;
    end
  end

  assign ADDR        = ir_load ? pc[ADDR_WIDTH-1:0] : alu_out[ADDR_WIDTH-1:0];
  assign DATA_OUT    = rt_data;
  assign MEM_REQ     = (state == ST_WAIT);
  assign BUSY        = (state == ST_WAIT);
  assign MEM_WE      = mem_we_q;
  assign ZERO        = (alu_out == '0);
  assign INSTRUCTION = ir;

endmodule

// File: tb/tb_data_path_mc.sv
// Scoreboard bench for data_path_mc: stimulus pushes expected outputs from an
// architectural reference model; a negedge monitor pops and compares them.
module tb_data_path_mc;

  localparam logic [31:0] RPC = 32'h0001000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [13:0] CTRL;
  logic [31:0] DATA_IN;
  logic        MEM_ACK;
  logic [31:0] DATA_OUT;
  logic [25:0] ADDR;
  logic        MEM_REQ, MEM_WE, BUSY, ZERO;
  logic [31:0] INSTRUCTION;

  data_path_mc #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (26),
    .REG_COUNT  (32),
    .RESET_PC   (RPC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CTRL        (CTRL),
    .DATA_IN     (DATA_IN),
    .MEM_ACK     (MEM_ACK),
    .DATA_OUT    (DATA_OUT),
    .ADDR        (ADDR),
    .MEM_REQ     (MEM_REQ),
    .MEM_WE      (MEM_WE),
    .BUSY        (BUSY),
    .ZERO        (ZERO),
    .INSTRUCTION (INSTRUCTION)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Architectural reference state.
  logic [31:0] m_r [32];
  logic [31:0] m_pc, m_ir, m_mdr, m_alu;
  logic        m_busy, m_we;

  function automatic string sig_name(input int s);
    case (s)
      0:       return "DATA_OUT";
      1:       return "ADDR";
      2:       return "ZERO";
      3:       return "BUSY";
      4:       return "INSTRUCTION";
      5:       return "MEM_REQ";
      default: return "MEM_WE";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int s);
    case (s)
      0:       return DATA_OUT;
      1:       return 32'(ADDR);
      2:       return 32'(ZERO);
      3:       return 32'(BUSY);
      4:       return INSTRUCTION;
      5:       return 32'(MEM_REQ);
      default: return 32'(MEM_WE);
    endcase
  endfunction

  always @(negedge CLK) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = observe(e.sig);
      n_tests++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", sig_name(e.sig), cyc, act, e.exp);
      end
    end
  end

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return ~(a | b);
      5:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6:       return a << b[4:0];
      7:       return a >> b[4:0];
      8:       return {imm[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [13:0] mk_ctrl(input logic pcl, input logic pcs, input logic irl,
                                          input logic rw, input logic [1:0] wb, input logic src,
                                          input logic [3:0] op, input logic rd, input logic wr);
    return {pcl, pcs, irl, rw, wb, src, op, rd, wr, 1'b0};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [10:0] low);
    return {6'd0, rs, rt, rd, low};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_r[i] = 32'h0;
    m_r[30] = 32'h03FF_FFFF;
    m_pc = RPC; m_ir = 32'h0; m_mdr = 32'h0; m_alu = 32'h0;
    m_busy = 1'b0; m_we = 1'b0;
  endtask

  task automatic expect_sig(input int s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all(input logic [13:0] c);
    expect_sig(0, m_r[m_ir[20:16]]);
    expect_sig(1, c[11] ? {6'd0, m_pc[25:0]} : {6'd0, m_alu[25:0]});
    expect_sig(2, 32'(m_alu == 32'h0));
    expect_sig(3, 32'(m_busy));
    expect_sig(4, m_ir);
    expect_sig(5, 32'(m_busy));
    expect_sig(6, 32'(m_busy && m_we));
  endtask

  task automatic model_step(input logic [13:0] c, input logic ack, input logic [31:0] din);
    logic [31:0] imm, a, b, res, val;
    logic [4:0]  dst;
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    if (!m_busy) begin
      a   = m_r[m_ir[25:21]];
      b   = c[7] ? imm : m_r[m_ir[20:16]];
      res = ref_alu(int'(c[6:3]), a, b, imm);
      if (c[10]) begin
        case (c[9:8])
          2'd0:    begin dst = m_ir[15:11]; val = m_alu; end
          2'd1:    begin dst = m_ir[20:16]; val = m_alu; end
          2'd2:    begin dst = m_ir[20:16]; val = m_mdr; end
          default: begin dst = 5'd31;       val = m_pc;  end
        endcase
        if (dst != 5'd0) m_r[dst] = val;
      end
      if (c[13]) m_pc = c[12] ? m_alu : m_pc + 32'd1;
      m_alu = res;
      if (c[11] || c[2] || c[1]) begin
        m_busy = 1'b1;
        m_we   = c[1];
      end
    end else if (ack) begin
      if (c[11])          m_ir  = din;
      if (c[2] && !c[1])  m_mdr = din;
      m_busy = 1'b0;
      m_we   = 1'b0;
    end
  endtask

  task automatic cycle(input logic [13:0] c, input logic ack, input logic [31:0] din);
    CTRL = c; MEM_ACK = ack; DATA_IN = din;
    check_all(c);
    if (RST) model_step(c, ack, din);
    @(posedge CLK); #1;
  endtask

  task automatic mem_access(input logic [13:0] c, input int dly, input logic [31:0] din);
    cycle(c, 1'b0, 32'h0);
    for (int k = 1; k <= dly; k++) cycle(c, (k == dly), (k == dly) ? din : 32'h0);
  endtask

  task automatic fetch(input logic [31:0] instr, input int dly);
    mem_access(mk_ctrl(0, 0, 1, 0, 2'd0, 0, 4'd0, 0, 0), dly, instr);
  endtask

  task automatic read_reg(input logic [4:0] r);
    fetch(mk_ir(5'd0, r, 5'd0, 11'd0), 1);
    cycle(14'h0, 1'b0, 32'h0);
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    fetch(mk_ir(5'd0, r, 5'd0, 11'd0), 1);
    mem_access(mk_ctrl(0, 0, 0, 0, 2'd0, 0, 4'd0, 1, 0), 2, v);
    cycle(mk_ctrl(0, 0, 0, 1, 2'd2, 0, 4'd0, 0, 0), 1'b0, 32'h0);
  endtask

  task automatic alu_wb(input logic [31:0] instr, input logic [3:0] op, input logic src);
    fetch(instr, 1);
    cycle(mk_ctrl(0, 0, 0, 0, 2'd0, src, op, 0, 0), 1'b0, 32'h0);
    cycle(mk_ctrl(0, 0, 0, 1, 2'd0, src, op, 0, 0), 1'b0, 32'h0);
    read_reg(instr[15:11]);
  endtask

  initial begin : stim
    logic [13:0] c;
    logic [1:0]  sel;
    RST = 1'b0; CTRL = 14'h0; DATA_IN = 32'h0; MEM_ACK = 1'b0;
    model_reset();
    @(posedge CLK); #1;

    // Reset values, then release away from the clock edge.
    cycle(14'h0, 1'b0, 32'h0);
    cycle(mk_ctrl(0, 0, 1, 0, 2'd0, 0, 4'd0, 0, 0), 1'b0, 32'h0);
    RST = 1'b1;

    // Fetch with a 3-cycle acknowledge delay, then read the stack-top register.
    fetch(mk_ir(5'd0, 5'd30, 5'd0, 11'd0), 3);
    cycle(14'h0, 1'b0, 32'h0);

    // R3 = R1 + R2 with 5 and -5.
    set_reg(5'd1, 32'd5);
    set_reg(5'd2, 32'hFFFF_FFFB);
    alu_wb(mk_ir(5'd1, 5'd2, 5'd3, 11'd0), 4'd0, 1'b0);

    // slt -1 < 1, sll 1 by 31, 0xFFFFFFFF + 1.
    set_reg(5'd1, 32'hFFFF_FFFF);
    set_reg(5'd2, 32'd1);
    alu_wb(mk_ir(5'd1, 5'd2, 5'd4, 11'd0), 4'd5, 1'b0);
    alu_wb(mk_ir(5'd1, 5'd2, 5'd6, 11'd0), 4'd0, 1'b0);
    set_reg(5'd1, 32'd1);
    alu_wb(mk_ir(5'd1, 5'd0, 5'd5, 11'd31), 4'd6, 1'b1);

    // Store R7 to ALU_OUT address, load back into R7, read+write collision.
    set_reg(5'd7, 32'hA5A5_1234);
    fetch(mk_ir(5'd0, 5'd7, 5'd0, 11'h040), 1);
    cycle(mk_ctrl(0, 0, 0, 0, 2'd0, 1, 4'd0, 0, 0), 1'b0, 32'h0);
    mem_access(mk_ctrl(0, 0, 0, 0, 2'd0, 1, 4'd0, 0, 1), 2, 32'h0);
    mem_access(mk_ctrl(0, 0, 0, 0, 2'd0, 1, 4'd0, 1, 0), 2, 32'h1357_9BDF);
    cycle(mk_ctrl(0, 0, 0, 1, 2'd2, 0, 4'd0, 0, 0), 1'b0, 32'h0);
    mem_access(mk_ctrl(0, 0, 0, 0, 2'd0, 1, 4'd0, 1, 1), 1, 32'hDEAD_BEEF);
    cycle(mk_ctrl(0, 0, 0, 1, 2'd2, 0, 4'd0, 0, 0), 1'b0, 32'h0);
    cycle(14'h0, 1'b0, 32'h0);

    // Writes to R0 are dropped; link write goes to R31.
    set_reg(5'd0, 32'h0000_DEAD);
    read_reg(5'd0);
    cycle(mk_ctrl(0, 0, 0, 1, 2'd3, 0, 4'd0, 0, 0), 1'b0, 32'h0);
    read_reg(5'd31);

    // Spurious acknowledges in IDLE leave IR and MDR untouched.
    cycle(14'h0, 1'b1, 32'h7777_7777);
    cycle(mk_ctrl(0, 0, 0, 1, 2'd2, 0, 4'd0, 0, 0), 1'b1, 32'h8888_8888);
    cycle(14'h0, 1'b0, 32'h0);

    // Reset in the middle of a pending read, then a late acknowledge.
    cycle(mk_ctrl(0, 0, 0, 0, 2'd0, 0, 4'd0, 1, 0), 1'b0, 32'h0);
    cycle(mk_ctrl(0, 0, 0, 0, 2'd0, 0, 4'd0, 1, 0), 1'b0, 32'h0);
    RST = 1'b0;
    CTRL = mk_ctrl(0, 0, 1, 0, 2'd0, 0, 4'd0, 0, 0);
    #1;
    model_reset();
    check_all(CTRL);
    @(posedge CLK); #1;
    CTRL = 14'h0;
    RST  = 1'b1;
    cycle(14'h0, 1'b1, 32'hCAFE_F00D);
    cycle(14'h0, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: fetch($urandom, int'($urandom_range(1, 4)));
        1: begin
          sel = 2'($urandom_range(1, 3));
          c = 14'($urandom);
          c[11] = 1'b0; c[2] = sel[0]; c[1] = sel[1];
          mem_access(c, int'($urandom_range(1, 3)), $urandom);
        end
        default: begin
          c = 14'($urandom);
          c[11] = 1'b0; c[2] = 1'b0; c[1] = 1'b0;
          cycle(c, 1'($urandom_range(0, 1)), $urandom);
        end
      endcase
    end

    cycle(14'h0, 1'b0, 32'h0);
    cycle(14'h0, 1'b0, 32'h0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
